// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | imem_loader: boot-time byte-stream loader for the instruction memory    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module imem_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          reload,
  output logic          WE,
  output logic [AW-1:0] WA,
  output logic [31:0]   WD,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    chk;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] hdr_last;
  logic [23:0]   asm_q;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [31:0]   wd_q;
  logic          accept;
  logic          word_end;
  logic          frame_end;

  // Header value H encodes N-1; clamp it to the last word the memory can hold.
  if (AW >= 8) begin : g_cap_wide
    assign hdr_last = AW'(rx_data);
  end else begin : g_cap_narrow
    localparam logic [7:0] MAX_IDX = 8'((1 << AW) - 1);
    assign hdr_last = (rx_data > MAX_IDX) ? {AW{1'b1}} : rx_data[AW-1:0];
  end

  assign rx_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign cpu_rst_n = (state == S_DONE);
  assign WE        = we_q;
  assign WA        = wa_q;
  assign WD        = wd_q;

  assign accept    = rx_valid && rx_ready;
  assign word_end  = (byte_cnt == 2'd3);
  assign frame_end = word_end && (word_idx == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR:  if (accept) state_nx = S_DATA;
      S_DATA: if (accept && frame_end) state_nx = S_CSUM;
      S_CSUM: if (accept) state_nx = (rx_data == chk) ? S_DONE : S_ERR;
      S_DONE: if (reload) state_nx = S_HDR;
      S_ERR:  if (reload) state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk      <= 8'd0;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      last_idx <= '0;
      asm_q    <= 24'd0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= 32'd0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_HDR: begin
          if (accept) begin
            last_idx <= hdr_last;
            chk      <= rx_data;
            byte_cnt <= 2'd0;
            word_idx <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q    <= {asm_q[15:0], rx_data};
            chk      <= chk ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
              we_q <= 1'b1;
              wa_q <= word_idx;
              wd_q <= {asm_q, rx_data};
              // Holding the index on the final word keeps it from wrapping.
              if (!frame_end) word_idx <= word_idx + 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            chk      <= 8'd0;
            byte_cnt <= 2'd0;
            word_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_imem_loader: directed self-checking bench for imem_loader           |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          reload;
  logic          WE;
  logic [AW-1:0] WA;
  logic [31:0]   WD;
  logic          cpu_rst_n;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_w [256];
  logic [7:0]  wa_q [$];
  logic [31:0] wd_q [$];
  logic        prev_we = 1'b0;

  imem_loader #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (WE) begin
      check("we_back_to_back", {31'd0, prev_we}, 32'd0);
      wa_q.push_back(WA);
      wd_q.push_back(WD);
    end
    prev_we <= WE;
  end

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit rl);
    int t;
    if (stall) begin
      while ($urandom_range(1, 0) == 1) begin
        rx_valid = 1'b0;
        reload   = 1'b0;
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    reload   = rl;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Sends header, n words from exp_w and checksum; stop_after>=0 truncates the frame.
  task automatic send_frame(input int n, input bit stall, input bit bad,
                            input int reload_at, input int stop_after);
    logic [7:0] c;
    logic [7:0] b;
    int k;
    wa_q.delete();
    wd_q.delete();
    c = 8'(n - 1);
    k = 0;
    send_byte(8'(n - 1), stall, k == reload_at);
    k++;
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        if (stop_after >= 0 && k >= stop_after) begin
          rx_valid = 1'b0;
          return;
        end
        b = exp_w[i][8*j +: 8];
        c = c ^ b;
        send_byte(b, stall, k == reload_at);
        k++;
      end
    end
    send_byte(bad ? ~c : c, stall, 1'b0);
    rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_count"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check({tag, "_wa"}, {24'd0, wa_q[i]}, i);
      check({tag, "_wd"}, wd_q[i], exp_w[i]);
    end
  endtask

  task automatic check_flags(input string tag, input bit d, input bit e, input bit rdy);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e});
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, d});
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, rdy});
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_flags("reload", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load_factorial();
    exp_w[0] = 32'h00008020; exp_w[1] = 32'h20100007; exp_w[2] = 32'h00008820;
    exp_w[3] = 32'h20110001; exp_w[4] = 32'h12000003; exp_w[5] = 32'h0230881c;
    exp_w[6] = 32'h2210ffff; exp_w[7] = 32'h08000004; exp_w[8] = 32'hac110000;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    reload   = 1'b0;
    #1;
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_wa", {24'd0, WA}, 32'd0);
    check("rst_wd", WD, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Factorial program, continuous stream.
    load_factorial();
    send_frame(9, 1'b0, 1'b0, -1, -1);
    check_flags("fact", 1'b1, 1'b0, 1'b0);
    check_writes("fact", 9);

    // Same frame with inverted checksum.
    pulse_reload();
    send_frame(9, 1'b0, 1'b1, -1, -1);
    check_flags("badsum", 1'b0, 1'b1, 1'b0);
    check_writes("badsum", 9);

    // Random stalls.
    pulse_reload();
    send_frame(9, 1'b1, 1'b0, -1, -1);
    check_flags("stall", 1'b1, 1'b0, 1'b0);
    check_writes("stall", 9);

    // Full depth.
    pulse_reload();
    for (int i = 0; i < 256; i++) exp_w[i] = 32'hA5000000 | i;
    send_frame(256, 1'b0, 1'b0, -1, -1);
    repeat (5) @(negedge clk);
    check_flags("full", 1'b1, 1'b0, 1'b0);
    check_writes("full", 256);
    check("full_last_wa", {24'd0, wa_q[$]}, 32'h000000FF);
    check("full_last_wd", wd_q[$], 32'hA50000FF);

    // Reload after DONE, with an ignored reload pulse in DATA.
    pulse_reload();
    exp_w[0] = 32'h12345678;
    send_frame(1, 1'b0, 1'b0, 2, -1);
    check_flags("reload1", 1'b1, 1'b0, 1'b0);
    check_writes("reload1", 1);

    // Reset after two bytes of word 3.
    pulse_reload();
    load_factorial();
    send_frame(9, 1'b0, 1'b0, -1, 15);
    check("midload_writes", wa_q.size(), 3);
    rst_n = 1'b0;
    #1;
    check("midrst_we", {31'd0, WE}, 32'd0);
    check("midrst_wa", {24'd0, WA}, 32'd0);
    check("midrst_wd", WD, 32'd0);
    check_flags("midrst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(9, 1'b0, 1'b0, -1, -1);
    check_flags("after_rst", 1'b1, 1'b0, 1'b0);
    check_writes("after_rst", 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the single-cycle MIPS instruction memory. Accepts a byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words, and drives a one-word-per-cycle write port into the 256-word instruction memory while holding the CPU in reset. On a verified checksum it releases the CPU; on a mismatch it keeps the CPU held and flags an error. It sits between the host byte source (UART receiver) and the instruction memory write port.

## Interface

- AW, 8, word address width; memory depth is 2^AW words, and WA maps to byte-address bits [AW+1:2].
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse that restarts loading; honoured only in DONE or ERR.
- WE  out  1  instruction memory write enable, one-cycle pulse per word.
- WA  out  AW  word address of the write.
- WD  out  32  instruction word to write.
- cpu_rst_n  out  1  CPU reset, active-low; held low until a load completes successfully.
- done  out  1  load completed and checksum matched.
- err  out  1  checksum mismatch.

## Operation

- A byte is accepted in any cycle where rx_valid && rx_ready.
- **Frame format:**
  - 1 header byte H; word count N = H+1, so N ranges 1..256 (capped at 2^AW).
  - Then 4N payload bytes, MSB first: the first byte of each word is WD[31:24].
  - Then 1 checksum byte, equal to the XOR of the header and all payload bytes.
- **States:**
  - HDR: rx_ready=1. On accept, latch N-1, set chk=H, and go to DATA.
  - DATA: rx_ready=1. Shift each byte into a 32-bit assembly register and XOR it into chk; a 2-bit byte counter tracks position.
    - On the 4th byte of a word, register WE=1, WA=word index, WD=assembled word for the next cycle, then increment the word index.
    - After the 4th byte of word N-1, go to CSUM.
  - CSUM: rx_ready=1. On accept, compare the byte with chk. Match goes to DONE; mismatch goes to ERR.
  - DONE: rx_ready=0, cpu_rst_n=1, done=1. A reload pulse goes to HDR.
  - ERR: rx_ready=0, cpu_rst_n=0, err=1. A reload pulse goes to HDR.
- **Reload** clears chk, the byte counter, the word index, done and err, and drives cpu_rst_n=0. A reload pulse in HDR, DATA or CSUM is ignored.
- Memory words at indices ≥ N are not touched and keep their prior contents.
- Word index width is AW. With N=256 the last write is WA=255, and the index never wraps into a second write.
- rx_valid low simply stalls the loader; no timeout. Partial words are held indefinitely.
- **Reset:** asserting rst_n mid-load aborts immediately. The partially written memory is left as is; the state returns to HDR.

## Timing

- **Reset values:** state=HDR, rx_ready=1, WE=0, WA=0, WD=0, cpu_rst_n=0, done=0, err=0, chk=0, counters=0.
- **Write latency:** WE is high exactly one cycle, the cycle after the 4th-byte handshake. WA and WD are stable in that cycle. WE is never high in two consecutive cycles, because a word needs at least 4 accepted bytes.
- **Throughput:** one byte per cycle when rx_valid is held high. An N-word frame takes 4N+2 cycles of accepts.
- **Release:** cpu_rst_n and done rise the cycle after the checksum handshake. This is never earlier than one cycle after the final WE pulse, so the CPU only sees a fully written memory.
- err rises the cycle after a mismatched checksum handshake.
- rx_ready falls in the same cycle that DONE or ERR is entered.
- rx_ready returns to 1 the cycle after reload is sampled.
- rx_ready is a state decode and does not depend combinationally on rx_valid.
- Reset takes effect asynchronously. The first accept is possible on the first rising edge after rst_n deasserts.

## Test plan

- **Factorial program load:** send H=0x08, then the 9 words 0x00008020, 0x20100007, 0x00008820, 0x20110001, 0x12000003, 0x0230881c, 0x2210ffff, 0x08000004, 0xac110000, then the correct XOR checksum, with rx_valid held high.
  - Expect 9 WE pulses at WA=0..8 with exactly those WD values.
  - Expect done=1 and cpu_rst_n=1 one cycle after the checksum, and rx_ready=0.
- **Bad checksum:** same frame with the checksum byte inverted.
  - All 9 writes still occur.
  - err=1, done=0, cpu_rst_n stays 0, rx_ready=0.
- **Random stalls:** same frame with rx_valid randomly low about 50% of cycles.
  - Identical WE/WA/WD sequence and final done=1.
  - No write occurs on a stall cycle unless it follows a 4th-byte accept.
- **Full depth:** H=0xFF with 256 words where word i = 0xA5000000 | i.
  - Expect 256 writes, last WA=0xFF, WD=0xA50000FF, and no extra write.
  - done=1.
- **Reload after DONE:** pulse reload, then send H=0x00, word 0x12345678, checksum 0x00^0x12^0x34^0x56^0x78.
  - Expect done to fall and cpu_rst_n=0 the cycle after reload.
  - One write at WA=0, WD=0x12345678.
  - done=1 again.
  - A reload pulse sent during DATA is ignored.
- **Reset mid-load:** assert rst_n after 2 bytes of word 3.
  - All outputs take their reset values immediately.
  - A subsequent full frame loads correctly from WA=0.
